add_serial_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one add_serial bit-serial 8-bit adder between 4 requesters.
- Per operation: captures the granted requester's operands, drives the adder's enable/operand inputs, waits out the adder's fixed latency, and returns the sum tagged with the requester id.
- Sits between requester logic and a single add_serial instance. The integration drives the adder's rst from ~rst_n.

---
 rtl/add_serial_arb.sv | 125 ++++++++++++
 tb/tb_add_serial_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_arb.sv
// Round-robin front end that time-shares one bit-serial 8-bit adder among four requesters.
// Each operation takes ADD_LAT+4 cycles: grant, launch pulse, wait, response, release pulse.
module add_serial_arb #(
   parameter int NREQ    = 4,
   parameter int ADD_LAT = 11,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [31:0]      a_in,
   input  logic [31:0]      b_in,
   output logic [3:0]       gnt,
   output logic             resp_valid,
   output logic [1:0]       resp_id,
   output logic [7:0]       resp_sum,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done,
   output logic             add_en,
   output logic [7:0]       add_a,
   output logic [7:0]       add_b,
   input  logic [7:0]       add_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESP,
      S_RELEASE
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(ADD_LAT - 1);

   state_t           state_q;
   logic [1:0]       ptr_q;
   logic [1:0]       id_q;
   logic [7:0]       wait_cnt_q;
   logic [7:0]       add_a_q;
   logic [7:0]       add_b_q;
   logic             resp_valid_q;
   logic [1:0]       resp_id_q;
   logic [7:0]       resp_sum_q;
   logic [CNT_W-1:0] ops_done_q;
   logic [CNT_W-1:0] ops_done_d;

   logic             sel_found;
   logic [1:0]       sel_idx;
   logic [1:0]       cand;

   // Scan starting at the round-robin pointer; first set request wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = ptr_q;
      cand      = 2'd0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_q + 2'(k);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign ops_done_d = ops_done_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ptr_q        <= 2'd0;
         id_q         <= 2'd0;
         wait_cnt_q   <= 8'd0;
         add_a_q      <= 8'd0;
         add_b_q      <= 8'd0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 2'd0;
         resp_sum_q   <= 8'd0;
         ops_done_q   <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sel_found) begin
                  add_a_q <= a_in[{sel_idx, 3'b000} +: 8];
                  add_b_q <= b_in[{sel_idx, 3'b000} +: 8];
                  id_q    <= sel_idx;
                  ptr_q   <= sel_idx + 2'd1;
                  state_q <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               wait_cnt_q <= 8'd0;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               wait_cnt_q <= wait_cnt_q + 8'd1;
               if (wait_cnt_q == WAIT_LAST) begin
                  resp_sum_q   <= add_out;
                  resp_id_q    <= id_q;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end
            end
            S_RESP: begin
               ops_done_q <= ops_done_d;
               state_q    <= S_RELEASE;
            end
            S_RELEASE: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   // Launch and release are never adjacent, so add_en cannot pulse twice in a row.
   assign gnt        = (state_q == S_IDLE && sel_found) ? (4'b0001 << sel_idx) : 4'b0000;
   assign busy       = (state_q != S_IDLE);
   assign add_en     = (state_q == S_LAUNCH) || (state_q == S_RELEASE);
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_sum   = resp_sum_q;
   assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_add_serial_arb.sv
// Directed bench for add_serial_arb; the shared adder is modelled as a plain 8-bit sum.
module tb_add_serial_arb;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] a_in, b_in;
   logic [3:0]  gnt;
   logic        resp_valid;
   logic [1:0]  resp_id;
   logic [7:0]  resp_sum;
   logic        busy;
   logic [15:0] ops_done;
   logic        add_en;
   logic [7:0]  add_a, add_b, add_out;

   logic        rst_n4;
   logic [3:0]  req4;
   logic [31:0] a4, b4;
   logic [3:0]  gnt4;
   logic        resp_valid4;
   logic [1:0]  resp_id4;
   logic [7:0]  resp_sum4;
   logic        busy4;
   logic [3:0]  ops_done4;
   logic        add_en4;
   logic [7:0]  add_a4, add_b4, add_out4;

   int checks = 0;
   int errors = 0;
   int resp_count = 0;

   assign add_out  = add_a + add_b;
   assign add_out4 = add_a4 + add_b4;

   add_serial_arb u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
      .busy(busy), .ops_done(ops_done), .add_en(add_en), .add_a(add_a),
      .add_b(add_b), .add_out(add_out)
   );

   add_serial_arb #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n4), .req(req4), .a_in(a4), .b_in(b4),
      .gnt(gnt4), .resp_valid(resp_valid4), .resp_id(resp_id4), .resp_sum(resp_sum4),
      .busy(busy4), .ops_done(ops_done4), .add_en(add_en4), .add_a(add_a4),
      .add_b(add_b4), .add_out(add_out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (resp_valid) begin
         resp_count <= resp_count + 1;
         $display("resp id=%0d sum=%02h ops_done=%0d", resp_id, resp_sum, ops_done);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(2);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (add_en !== 1'b0) begin errors++; $display("FAIL reset_add_en got %b want 0", add_en); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done got %0d want 0", ops_done); end
      checks++; if ({add_a, add_b, resp_sum, resp_id} !== 26'd0) begin errors++; $display("FAIL reset_data got %h want 0", {add_a, add_b, resp_sum, resp_id}); end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single;
      req = 4'b0001; a_in = 32'h0000000F; b_in = 32'h00000001;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b want 0", busy); end
      tick(1);
      req = 4'b0000;
      #1;
      checks++; if (add_en !== 1'b1) begin errors++; $display("FAIL single_launch got %b want 1", add_en); end
      checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_busy got gnt=%b busy=%b want 0000/1", gnt, busy); end
      checks++; if (add_a !== 8'h0F || add_b !== 8'h01) begin errors++; $display("FAIL single_operands got %h/%h want 0f/01", add_a, add_b); end
      tick(11);
      checks++; if (resp_valid !== 1'b0 || add_en !== 1'b0) begin errors++; $display("FAIL single_early got rv=%b en=%b want 0/0", resp_valid, add_en); end
      tick(1);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid got %b want 1", resp_valid); end
      checks++; if (resp_id !== 2'd0 || resp_sum !== 8'h10) begin errors++; $display("FAIL single_resp got id=%0d sum=%h want 0/10", resp_id, resp_sum); end
      tick(1);
      checks++; if (add_en !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_release got en=%b rv=%b want 1/0", add_en, resp_valid); end
      tick(1);
      checks++; if (busy !== 1'b0 || add_en !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b en=%b want 0/0", busy, add_en); end
      checks++; if (ops_done !== 16'd1) begin errors++; $display("FAIL single_ops_done got %0d want 1", ops_done); end
   endtask

   task automatic test_overflow;
      req = 4'b0100; a_in = 32'h00FF0000; b_in = 32'h00020000;
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ovf_gnt got %b want 0100", gnt); end
      tick(1);
      req = 4'b0000;
      tick(12);
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 8'h01) begin errors++; $display("FAIL ovf_resp got rv=%b id=%0d sum=%h want 1/2/01", resp_valid, resp_id, resp_sum); end
      tick(2);
      checks++; if (ops_done !== 16'd2 || busy !== 1'b0) begin errors++; $display("FAIL ovf_done got ops=%0d busy=%b want 2/0", ops_done, busy); end
   endtask

   task automatic test_contention;
      logic [7:0] exp_sum [4];
      logic [3:0] exp_gnt;
      int         id;
      exp_sum = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst_n = 1'b0; req = 4'b1111; a_in = 32'h40302010; b_in = 32'h04030201;
      tick(1);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         id = k % 4;
         exp_gnt = 4'b0001 << id;
         checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL cont_gnt%0d got %b want %b", k, gnt, exp_gnt); end
         tick(13);
         checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(id) || resp_sum !== exp_sum[id]) begin
            errors++; $display("FAIL cont_resp%0d got rv=%b id=%0d sum=%h want 1/%0d/%h", k, resp_valid, resp_id, resp_sum, id, exp_sum[id]);
         end
         if (k == 4) req = 4'b0000;
         tick(2);
      end
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL cont_idle got gnt=%b busy=%b want 0000/0", gnt, busy); end
   endtask

   task automatic test_fairness;
      req = 4'b0001; a_in = 32'h80000012; b_in = 32'h80000034;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL fair_gnt0 got %b want 0001", gnt); end
      tick(1);
      req = 4'b1001;
      tick(12);
      checks++; if (resp_id !== 2'd0 || resp_sum !== 8'h46) begin errors++; $display("FAIL fair_resp0 got id=%0d sum=%h want 0/46", resp_id, resp_sum); end
      tick(2);
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL fair_gnt3 got %b want 1000", gnt); end
      tick(1);
      req = 4'b0001;
      tick(12);
      checks++; if (resp_id !== 2'd3 || resp_sum !== 8'h00) begin errors++; $display("FAIL fair_resp3 got id=%0d sum=%h want 3/00", resp_id, resp_sum); end
      tick(2);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL fair_gnt0b got %b want 0001", gnt); end
      tick(1);
      req = 4'b0000;
      tick(14);
   endtask

   task automatic test_mid_reset;
      int rc;
      req = 4'b0010; a_in = 32'h00005500; b_in = 32'h00000100;
      #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mrst_gnt got %b want 0010", gnt); end
      tick(1);
      req = 4'b0000;
      tick(5);
      rc = resp_count;
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || add_en !== 1'b0 || gnt !== 4'b0000 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL mrst_ctrl got busy=%b en=%b gnt=%b rv=%b want 0", busy, add_en, gnt, resp_valid);
      end
      checks++; if ({add_a, add_b, resp_sum, resp_id} !== 26'd0 || ops_done !== 16'd0) begin
         errors++; $display("FAIL mrst_data got %h ops=%0d want 0", {add_a, add_b, resp_sum, resp_id}, ops_done);
      end
      tick(20);
      checks++; if (resp_count !== rc) begin errors++; $display("FAIL mrst_no_resp got %0d want %0d", resp_count, rc); end
      req = 4'b1010; a_in = 32'h07005500; b_in = 32'h01000100;
      #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mrst_ptr got %b want 0010", gnt); end
      tick(1);
      req = 4'b0000;
      tick(12);
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 8'h56) begin errors++; $display("FAIL mrst_resp got rv=%b id=%0d sum=%h want 1/1/56", resp_valid, resp_id, resp_sum); end
      tick(2);
   endtask

   task automatic test_wrap;
      int ng;
      ng = 0;
      rst_n4 = 1'b1; req4 = 4'b0001; a4 = 32'h00000005; b4 = 32'h00000003;
      #1;
      for (int c = 0; c < 600 && ng < 17; c++) begin
         if (gnt4 != 4'b0000) ng++;
         tick(1);
      end
      req4 = 4'b0000;
      checks++; if (ng != 17) begin errors++; $display("FAIL wrap_grants got %0d want 17", ng); end
      tick(16);
      checks++; if (ops_done4 !== 4'd1 || busy4 !== 1'b0) begin errors++; $display("FAIL wrap_ops got ops=%0d busy=%b want 1/0", ops_done4, busy4); end
      checks++; if (resp_sum4 !== 8'h08) begin errors++; $display("FAIL wrap_sum got %h want 08", resp_sum4); end
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0000; a_in = '0; b_in = '0;
      rst_n4 = 1'b0; req4 = 4'b0000; a4 = '0; b4 = '0;
      tick(1);
      test_reset();
      test_single();
      test_overflow();
      test_contention();
      test_fairness();
      test_mid_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
